// File: rtl/led_p2s_pkg.sv
// Shared types and constants for the LED parallel-to-serial sequencer.
// Holds the frame state encoding, default geometry and the frame-length helper.
package led_p2s_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CLK_DIV = 4;

  // Cycles from the accepting edge until DONE is entered.
  function automatic int frame_len(input int data_w, input int clk_div);
    return 2 * clk_div * data_w + clk_div;
  endfunction

endpackage

// File: rtl/led_p2s_ctrl_if.sv
// Start/busy request side and serial LED chain pins of the P2S sequencer.
// master drives start/p_data; slave (the sequencer) drives the chain outputs.
interface led_p2s_ctrl_if
  import led_p2s_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              start;
  logic [DATA_W-1:0] p_data;
  logic              sclk;
  logic              sdata;
  logic              latch;
  logic              busy;
  logic              done;

  modport master (
    output start, p_data,
    input  sclk, sdata, latch, busy, done
  );

  modport slave (
    input  start, p_data,
    output sclk, sdata, latch, busy, done
  );
endinterface

// File: rtl/p2s_tick_gen.sv
// Half-period divider: counts 0..CLK_DIV-1 while enabled, tick_o on the last count.
// Synchronous clear restarts the count so every state entry gets a full half-period.
module p2s_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/led_p2s_ctrl.sv
// Serialises a DATA_W word onto the LED chain (sclk/sdata/latch), done after 2*CLK_DIV*DATA_W+CLK_DIV cycles.
// start is accepted only in IDLE; busy covers the frame. LED_P2S_LSB_FIRST_EN selects LSB-first order.
module led_p2s_ctrl
  import led_p2s_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input logic          clk,
  input logic          rst,
  led_p2s_ctrl_if.slave bus
);
  localparam int BW = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tick, div_en, div_clr;
  logic              sclk_q, sdata_q, latch_q, busy_q, done_q;
  logic              sclk_d, sdata_d, latch_d, busy_d, done_d;
  logic [DATA_W-1:0] sreg_shift;
  logic              out_bit;

  assign div_en  = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LATCH);
  assign div_clr = (state_d != state_q);

  p2s_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (div_en),
    .clr_i (div_clr),
    .tick_o(tick)
  );

`ifdef LED_P2S_LSB_FIRST_EN
  assign sreg_shift = {1'b0, sreg_q[DATA_W-1:1]};
  assign out_bit    = sreg_d[0];
`else
  assign sreg_shift = {sreg_q[DATA_W-2:0], 1'b0};
  assign out_bit    = sreg_d[DATA_W-1];
`endif

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d    = bus.p_data;
          bit_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: if (tick) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            state_d = LATCH;
          end else begin
            sreg_d    = sreg_shift;
            bit_cnt_d = bit_cnt_q + BW'(1);
            state_d   = SHIFT_LO;
          end
        end
      end
      LATCH:   if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so the board pins never glitch.
    sclk_d  = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    busy_d  = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == LATCH);
    done_d  = (state_d == DONE);
    sdata_d = busy_d && out_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk  = sclk_q;
  assign bus.sdata = sdata_q;
  assign bus.latch = latch_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
